dram_bank_ctrl: RTL and testbench

Parametrised single-bank DRAM behavioural controller. It replaces the flat, always-available memory model with a row-buffer model that has a valid/ready request port, activate/precharge/CAS timing, byte-enabled writes and periodic refresh. It sits between the system-side requesters and the memory array, and gives the rest of the design DRAM-like latency for performance and protocol testing.

---
 rtl/dram_pkg.sv | 39 +++
 rtl/dram_timing_counter.sv | 39 +++
 rtl/dram_bank_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_dram_bank_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared types, default timing and address helpers for the single-bank DRAM model.
package dram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OPEN,
        PRECHARGE,
        ACTIVATE,
        CAS,
        REFRESH
    } dram_state_t;

    localparam int unsigned DEF_ADDR_W           = 12;
    localparam int unsigned DEF_DATA_W           = 8;
    localparam int unsigned DEF_ROW_W            = 6;
    localparam int unsigned DEF_T_RCD            = 2;
    localparam int unsigned DEF_T_RP             = 2;
    localparam int unsigned DEF_T_CL             = 2;
    localparam int unsigned DEF_T_RFC            = 4;
    localparam int unsigned DEF_REFRESH_INTERVAL = 64;

    // Width of the shared wait counter; every timing value must fit below 2^TCNT_W.
    localparam int unsigned TCNT_W = 8;

    // Row = upper row_w bits of an addr_w-bit word address.
    function automatic logic [31:0] row_of(input logic [31:0] addr,
                                           input int unsigned addr_w,
                                           input int unsigned row_w);
        return addr >> (addr_w - row_w);
    endfunction

    // Column = remaining low bits below the row field.
    function automatic logic [31:0] col_of(input logic [31:0] addr,
                                           input int unsigned addr_w,
                                           input int unsigned row_w);
        return addr & ((32'd1 << (addr_w - row_w)) - 32'd1);
    endfunction

endpackage

// File: rtl/dram_timing_counter.sv
// Loadable down-counter; done is high while the count sits at zero.
// Loading N-1 on entry to a state keeps that state for exactly N cycles.
module dram_timing_counter
    import dram_pkg::*;
#(
    parameter int unsigned W = TCNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise decrement until zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/dram_bank_ctrl.sv
// Single-bank DRAM behavioural controller: row buffer, activate/precharge/CAS
// timing, byte-enabled writes. Optional periodic refresh is built when the
// macro DRAM_REFRESH_EN is defined.
module dram_bank_ctrl
    import dram_pkg::*;
#(
    parameter int unsigned ADDR_W           = DEF_ADDR_W,
    parameter int unsigned DATA_W           = DEF_DATA_W,
    parameter int unsigned ROW_W            = DEF_ROW_W,
    parameter int unsigned T_RCD            = DEF_T_RCD,
    parameter int unsigned T_RP             = DEF_T_RP,
    parameter int unsigned T_CL             = DEF_T_CL,
    parameter int unsigned T_RFC            = DEF_T_RFC,
    parameter int unsigned REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  row_open,
    output logic                  refresh_active
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [TCNT_W-1:0] LD_RCD = TCNT_W'(T_RCD - 1);
    localparam logic [TCNT_W-1:0] LD_RP  = TCNT_W'(T_RP - 1);
    localparam logic [TCNT_W-1:0] LD_CL  = TCNT_W'(T_CL - 1);

    // Marker scope that only appears in the elaborated hierarchy for an unusable configuration.
    if (T_RCD < 1 || T_RP < 1 || T_CL < 1 || T_RFC < 1 || (DATA_W % 8) != 0 ||
        REFRESH_INTERVAL <= 2 * T_RP + T_RCD + T_CL + T_RFC) begin : g_bad_timing_cfg
    end

    dram_state_t         state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]       be_q, be_d;
    logic [ROW_W-1:0]    open_row_q, open_row_d;
    logic                inflight_q, inflight_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                tc_load;
    logic [TCNT_W-1:0]   tc_val;
    logic                tc_done;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [NB-1:0]       mem_be;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                refresh_pending;
    logic                accept;
    logic [ROW_W-1:0]    req_row;
    logic [ROW_W-1:0]    held_row;

    assign req_row  = ROW_W'(row_of(32'(req_addr), ADDR_W, ROW_W));
    assign held_row = ROW_W'(row_of(32'(addr_q), ADDR_W, ROW_W));

    assign req_ready = ((state_q == IDLE) || (state_q == OPEN)) && !refresh_pending;
    assign accept    = req_valid && req_ready;
    assign row_open  = (state_q == OPEN) || (state_q == CAS);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    dram_timing_counter #(.W(TCNT_W)) u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tc_load),
        .load_val (tc_val),
        .done     (tc_done)
    );

    // Next-state, request capture, array write strobe and response generation.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        open_row_d  = open_row_q;
        inflight_d  = inflight_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        tc_load     = 1'b0;
        tc_val      = '0;
        mem_we      = 1'b0;
        mem_addr    = addr_q;
        mem_wdata   = wdata_q;
        mem_be      = be_q;

        if (accept) begin
            addr_d  = req_addr;
            we_d    = req_we;
            wdata_d = req_wdata;
            be_d    = req_be;
        end

        unique case (state_q)
            IDLE: begin
                if (refresh_pending) begin
`ifdef DRAM_REFRESH_EN
                    state_d = REFRESH;
                    tc_load = 1'b1;
                    tc_val  = TCNT_W'(T_RFC - 1);
`endif
                end else if (accept) begin
                    inflight_d = 1'b1;
                    state_d    = ACTIVATE;
                    tc_load    = 1'b1;
                    tc_val     = LD_RCD;
                end
            end
            OPEN: begin
                if (refresh_pending) begin
                    inflight_d = 1'b0;
                    state_d    = PRECHARGE;
                    tc_load    = 1'b1;
                    tc_val     = LD_RP;
                end else if (accept) begin
                    if (req_row == open_row_q) begin
                        if (req_we) begin
                            mem_we    = 1'b1;
                            mem_addr  = req_addr;
                            mem_wdata = req_wdata;
                            mem_be    = req_be;
                        end else begin
                            inflight_d = 1'b1;
                            state_d    = CAS;
                            tc_load    = 1'b1;
                            tc_val     = LD_CL;
                        end
                    end else begin
                        inflight_d = 1'b1;
                        state_d    = PRECHARGE;
                        tc_load    = 1'b1;
                        tc_val     = LD_RP;
                    end
                end
            end
            PRECHARGE: begin
                // inflight distinguishes a row miss from the refresh-driven close.
                if (tc_done) begin
                    if (inflight_q) begin
                        state_d = ACTIVATE;
                        tc_load = 1'b1;
                        tc_val  = LD_RCD;
                    end else begin
`ifdef DRAM_REFRESH_EN
                        state_d = REFRESH;
                        tc_load = 1'b1;
                        tc_val  = TCNT_W'(T_RFC - 1);
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
            ACTIVATE: begin
                if (tc_done) begin
                    open_row_d = held_row;
                    if (we_q) begin
                        mem_we     = 1'b1;
                        inflight_d = 1'b0;
                        state_d    = OPEN;
                    end else begin
                        state_d = CAS;
                        tc_load = 1'b1;
                        tc_val  = LD_CL;
                    end
                end
            end
            CAS: begin
                if (tc_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = mem_q[addr_q];
                    inflight_d  = 1'b0;
                    state_d     = OPEN;
                end
            end
            REFRESH: begin
                if (tc_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers; an in-flight request is simply dropped by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            open_row_q  <= '0;
            inflight_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            open_row_q  <= open_row_d;
            inflight_q  <= inflight_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Storage array with per-byte write enables; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_addr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
                end
            end
        end
    end

`ifdef DRAM_REFRESH_EN
    localparam int unsigned RC_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_INTERVAL - 1);

    logic [RC_W-1:0] rcnt_q, rcnt_d;
    logic            rpend_q, rpend_d;

    // Free-running interval counter; pending sets on wrap and clears on entry to REFRESH.
    always_comb begin
        rcnt_d  = (rcnt_q == RC_LAST) ? '0 : rcnt_q + RC_W'(1);
        rpend_d = rpend_q;
        if ((state_d == REFRESH) && (state_q != REFRESH)) begin
            rpend_d = 1'b0;
        end
        if (rcnt_q == RC_LAST) begin
            rpend_d = 1'b1;
        end
    end

    // Refresh counter and pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q  <= '0;
            rpend_q <= 1'b0;
        end else begin
            rcnt_q  <= rcnt_d;
            rpend_q <= rpend_d;
        end
    end

    assign refresh_pending = rpend_q;
    assign refresh_active  = (state_q == REFRESH);
`else
    assign refresh_pending = 1'b0;
    assign refresh_active  = 1'b0;
`endif

endmodule

// File: tb/tb_dram_bank_ctrl.sv
// Self-checking bench for dram_bank_ctrl (DATA_W=32, default timing).
module tb_dram_bank_ctrl;

    localparam int T_RCD = 2;
    localparam int T_RP  = 2;
    localparam int T_CL  = 2;
    localparam int T_RFC = 4;
    localparam int RI    = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        row_open;
    logic        refresh_active;

    int checks = 0;
    int errors = 0;
    int edge_cnt;

    // Behavioural model state: word contents, known-byte masks, open row.
    logic [31:0] mdl_mem   [int];
    logic [3:0]  mdl_known [int];
    bit          mdl_open = 0;
    int          mdl_row  = 0;
    int          mdl_last = 1;

    dram_bank_ctrl #(
        .ADDR_W(12), .DATA_W(32), .ROW_W(6),
        .T_RCD(T_RCD), .T_RP(T_RP), .T_CL(T_CL),
        .T_RFC(T_RFC), .REFRESH_INTERVAL(RI)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_be         (req_be),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .row_open       (row_open),
        .refresh_active (refresh_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // True when a refresh request point (multiple of RI edges) lies in [lo, hi].
    function automatic bit refresh_between(input int lo, input int hi);
`ifdef DRAM_REFRESH_EN
        int first;
        if (lo < 1) lo = 1;
        first = ((lo + RI - 1) / RI) * RI;
        return first <= hi;
`else
        return (lo > hi) && (lo < 0);
`endif
    endfunction

    task automatic do_reset();
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mdl_open = 0;
        mdl_last = 1;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (req_ready) begin
                ok = 1;
                return;
            end
            @(negedge clk);
        end
        check("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    // Drive one request; lat = cycles after the accept edge until rsp_valid (read)
    // or until req_ready returns (write).
    task automatic issue(input bit we, input logic [11:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, output int lat, output logic [31:0] rd,
                         output int acc_e);
        bit ok;
        lat = -1;
        rd  = '0;
        wait_ready(ok);
        acc_e = edge_cnt + 1;
        if (!ok) return;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (we ? req_ready : rsp_valid) begin
                lat = k;
                rd  = rsp_rdata;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Expected latency from row state, then apply the access to the model.
    task automatic model_access(input bit we, input logic [11:0] addr, input logic [31:0] wd,
                                input logic [3:0] be, input int acc_e, output int exp_lat);
        int  row;
        bit  hit;
        bit  closed;
        logic [31:0] w;
        logic [3:0]  kn;
        row = int'(addr) / 64;
        if (mdl_open && refresh_between(mdl_last, acc_e - 1)) mdl_open = 0;
        hit    = mdl_open && (mdl_row == row);
        closed = !mdl_open;
        if (we) exp_lat = hit ? 0 : (closed ? T_RCD : T_RP + T_RCD);
        else    exp_lat = hit ? T_CL : (closed ? T_RCD + T_CL : T_RP + T_RCD + T_CL);
        if (we) begin
            w  = mdl_mem.exists(int'(addr)) ? mdl_mem[int'(addr)] : 32'h0;
            kn = mdl_known.exists(int'(addr)) ? mdl_known[int'(addr)] : 4'h0;
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    w[b*8 +: 8] = wd[b*8 +: 8];
                    kn[b] = 1'b1;
                end
            end
            mdl_mem[int'(addr)]   = w;
            mdl_known[int'(addr)] = kn;
        end
        mdl_open = 1;
        mdl_row  = row;
        mdl_last = acc_e;
    endtask

    typedef struct {
        bit          we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int          lat, acc_e, exp_lat, bad;
        logic [31:0] rd, last_d, sd;

        tbl[0]  = '{1'b1, 12'h040, 32'h000000A5, 4'hF, 2, 32'h0};
        tbl[1]  = '{1'b1, 12'h041, 32'h12345678, 4'hF, 0, 32'h0};
        tbl[2]  = '{1'b0, 12'h040, 32'h0,        4'h0, 2, 32'h000000A5};
        tbl[3]  = '{1'b0, 12'h041, 32'h0,        4'h0, 2, 32'h12345678};
        tbl[4]  = '{1'b1, 12'hFC0, 32'hCAFEF00D, 4'hF, 4, 32'h0};
        tbl[5]  = '{1'b0, 12'hFC0, 32'h0,        4'h0, 2, 32'hCAFEF00D};
        tbl[6]  = '{1'b0, 12'h041, 32'h0,        4'h0, 6, 32'h12345678};
        tbl[7]  = '{1'b1, 12'h041, 32'hDEADBEEF, 4'hF, 0, 32'h0};
        tbl[8]  = '{1'b1, 12'h041, 32'h00000011, 4'h1, 0, 32'h0};
        tbl[9]  = '{1'b0, 12'h041, 32'h0,        4'h0, 2, 32'hDEADBE11};
        tbl[10] = '{1'b1, 12'h041, 32'hFFFFFFFF, 4'h0, 0, 32'h0};
        tbl[11] = '{1'b0, 12'h041, 32'h0,        4'hF, 2, 32'hDEADBE11};
        tbl[12] = '{1'b0, 12'hFC0, 32'h0,        4'h0, 6, 32'hCAFEF00D};
        tbl[13] = '{1'b1, 12'h040, 32'h11223344, 4'hA, 4, 32'h0};
        tbl[14] = '{1'b0, 12'h040, 32'h0,        4'h0, 2, 32'h110033A5};

        // Reset values.
        do_reset();
        check("rst_ready",   32'(req_ready), 32'd1);
        check("rst_rsp_vld", 32'(rsp_valid), 32'd0);
        check("rst_rdata",   rsp_rdata,      32'd0);
        check("rst_row_open", 32'(row_open), 32'd0);
        check("rst_refresh", 32'(refresh_active), 32'd0);

        // Directed table.
        for (int i = 0; i < 15; i++) begin
            issue(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, lat, rd, acc_e);
            model_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, acc_e, exp_lat);
            check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            if (!tbl[i].we) check($sformatf("tbl%0d_data", i), rd, tbl[i].rdata);
            check($sformatf("tbl%0d_row_open", i), 32'(row_open), 32'd1);
        end

        // Reset during CAS of a closed read.
        do_reset();
        begin
            bit ok;
            wait_ready(ok);
            req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h040; req_be = 4'h0;
            @(negedge clk);
            req_valid = 1'b0;
            repeat (T_RCD) @(negedge clk);
            check("cas_row_open", 32'(row_open), 32'd1);
            rst_n = 1'b0;
            #1;
            check("midrst_ready",   32'(req_ready), 32'd1);
            check("midrst_rsp_vld", 32'(rsp_valid), 32'd0);
            check("midrst_rdata",   rsp_rdata,      32'd0);
            check("midrst_row_open", 32'(row_open), 32'd0);
            check("midrst_refresh", 32'(refresh_active), 32'd0);
            bad = 0;
            repeat (3) begin
                @(negedge clk);
                if (rsp_valid) bad++;
            end
            rst_n = 1'b1;
            mdl_open = 0;
            mdl_last = 1;
            repeat (6) begin
                @(negedge clk);
                if (rsp_valid) bad++;
            end
            check("midrst_no_rsp", 32'(bad), 32'd0);
            issue(1'b0, 12'h040, 32'h0, 4'h0, lat, rd, acc_e);
            model_access(1'b0, 12'h040, 32'h0, 4'h0, acc_e, exp_lat);
            check("postrst_lat",  32'(lat), 32'(T_RCD + T_CL));
            check("postrst_data", rd, 32'h110033A5);
        end

        // Randomised traffic against the model.
        for (int n = 0; n < 200; n++) begin
            bit          we;
            int          r;
            logic [11:0] a;
            logic [31:0] wd;
            logic [3:0]  be;
            r  = int'($urandom_range(0, 3));
            if (r == 3) r = 63;
            a  = 12'(r * 64 + int'($urandom_range(0, 3)));
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            be = 4'($urandom);
            issue(we, a, wd, be, lat, rd, acc_e);
            if (!we) begin
                model_access(we, a, wd, be, acc_e, exp_lat);
                check($sformatf("rnd%0d_rd_lat", n), 32'(lat), 32'(exp_lat));
                if (mdl_known.exists(int'(a)) && mdl_known[int'(a)] == 4'hF)
                    check($sformatf("rnd%0d_rd_data", n), rd, mdl_mem[int'(a)]);
            end else begin
                model_access(we, a, wd, be, acc_e, exp_lat);
                if (!refresh_between(acc_e, acc_e + exp_lat))
                    check($sformatf("rnd%0d_wr_lat", n), 32'(lat), 32'(exp_lat));
            end
        end

`ifdef DRAM_REFRESH_EN
        // Held hit-write stream across the first refresh point.
        do_reset();
        begin
            int first_low, first_rf, pre_cnt, rf_cnt;
            issue(1'b1, 12'h040, 32'h0BADF00D, 4'hF, lat, rd, acc_e);
            last_d = 32'h0BADF00D;
            sd = 32'h100;
            first_low = -1; first_rf = -1; pre_cnt = 0; rf_cnt = 0;
            for (int i = 0; i < 120 && edge_cnt < RI + 12; i++) begin
                if (first_low < 0) begin
                    if (req_ready) begin
                        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h040;
                        req_wdata = sd; req_be = 4'hF;
                        last_d = sd;
                        sd = sd + 1;
                    end else begin
                        first_low = edge_cnt;
                        req_valid = 1'b0;
                    end
                end
                if (refresh_active) begin
                    rf_cnt++;
                    if (first_rf < 0) first_rf = edge_cnt;
                end
                if (first_low >= 0 && !req_ready && !refresh_active && !row_open && rf_cnt == 0)
                    pre_cnt++;
                @(negedge clk);
            end
            req_valid = 1'b0;
            check("rf_first_low", 32'(first_low), 32'(RI));
            check("rf_precharge", 32'(pre_cnt), 32'(T_RP));
            check("rf_active_len", 32'(rf_cnt), 32'(T_RFC));
            check("rf_active_start", 32'(first_rf), 32'(RI + T_RP + 1));
            check("rf_ready_back", 32'(req_ready), 32'd1);
            check("rf_row_closed", 32'(row_open), 32'd0);
            mdl_mem[12'h040] = last_d;
            mdl_known[12'h040] = 4'hF;
            mdl_open = 0;
            mdl_last = edge_cnt;
            issue(1'b0, 12'h040, 32'h0, 4'h0, lat, rd, acc_e);
            model_access(1'b0, 12'h040, 32'h0, 4'h0, acc_e, exp_lat);
            check("rf_next_lat", 32'(lat), 32'(T_RCD + T_CL));
            check("rf_next_data", rd, last_d);
        end
`else
        // Long hit stream with refresh compiled out.
        do_reset();
        begin
            int rf_seen;
            issue(1'b1, 12'h040, 32'h0BADF00D, 4'hF, lat, rd, acc_e);
            last_d = 32'h0BADF00D;
            sd = 32'h200;
            bad = 0;
            rf_seen = 0;
            for (int i = 0; i < 500; i++) begin
                if (!req_ready) bad++;
                if (refresh_active) rf_seen++;
                req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h040;
                req_wdata = sd; req_be = 4'hF;
                if (req_ready) last_d = sd;
                sd = sd + 1;
                @(negedge clk);
            end
            req_valid = 1'b0;
            check("norf_ready_drops", 32'(bad), 32'd0);
            check("norf_refresh_seen", 32'(rf_seen), 32'd0);
            issue(1'b0, 12'h040, 32'h0, 4'h0, lat, rd, acc_e);
            check("norf_read_lat", 32'(lat), 32'(T_CL));
            check("norf_read_data", rd, last_d);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
